// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for a video reader and a CPU; one access per IDLE->ISSUE->ACK pass.
// Video has priority until the CPU has lost P_cpu_max_wait consecutive arbitrations.
module mem_arbiter #(
  parameter int P_data_bits    = 8,
  parameter int P_addr_bits    = 16,
  parameter int P_cpu_max_wait = 6
) (
  input  logic                   I_clock,
  input  logic                   I_reset,
  input  logic                   I_vid_req,
  input  logic [P_addr_bits-1:0] I_vid_addr,
  output logic                   O_vid_ack,
  output logic [P_data_bits-1:0] O_vid_data,
  input  logic                   I_cpu_req,
  input  logic                   I_cpu_rdwr,
  input  logic [P_addr_bits-1:0] I_cpu_addr,
  input  logic [P_data_bits-1:0] I_cpu_wr_data,
  output logic                   O_cpu_ack,
  output logic [P_data_bits-1:0] O_cpu_rd_data,
  output logic [P_addr_bits-1:0] O_mem_addr,
  output logic                   O_mem_rden,
  output logic                   O_mem_wren,
  output logic [P_data_bits-1:0] O_mem_data,
  input  logic [P_data_bits-1:0] I_mem_data,
  output logic                   O_busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_ACK} state_t;

  localparam logic [7:0] C_MAX_WAIT = 8'(P_cpu_max_wait);

  state_t                 state_q, state_d;
  logic                   win_cpu_q, win_cpu_d;
  logic                   rd_q, rd_d;
  logic [P_addr_bits-1:0] addr_q, addr_d;
  logic [P_data_bits-1:0] wdata_q, wdata_d;
  logic [7:0]             starve_q, starve_d;
  logic [P_data_bits-1:0] vid_data_q, cpu_data_q;

  always_ff @(posedge I_clock) begin
    if (I_reset) begin
      state_q    <= S_IDLE;
      win_cpu_q  <= 1'b0;
      rd_q       <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      starve_q   <= '0;
      vid_data_q <= '0;
      cpu_data_q <= '0;
    end else begin
      state_q   <= state_d;
      win_cpu_q <= win_cpu_d;
      rd_q      <= rd_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      starve_q  <= starve_d;
      if (O_vid_ack) vid_data_q <= I_mem_data;
      if (O_cpu_ack) cpu_data_q <= I_mem_data;
    end
  end

  always_comb begin
    state_d   = state_q;
    win_cpu_d = win_cpu_q;
    rd_d      = rd_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    starve_d  = starve_q;
    case (state_q)
      S_IDLE: begin
        if (I_cpu_req && (!I_vid_req || starve_q == C_MAX_WAIT)) begin
          state_d   = S_ISSUE;
          win_cpu_d = 1'b1;
          rd_d      = I_cpu_rdwr;
          addr_d    = I_cpu_addr;
          wdata_d   = I_cpu_wr_data;
          starve_d  = '0;
        end else if (I_vid_req) begin
          state_d   = S_ISSUE;
          win_cpu_d = 1'b0;
          rd_d      = 1'b1;
          addr_d    = I_vid_addr;
          // Video only beats a waiting CPU below the limit, so this never overshoots.
          starve_d  = I_cpu_req ? starve_q + 8'd1 : 8'd0;
        end else begin
          starve_d  = '0;
        end
      end
      S_ISSUE: state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    O_busy        = (state_q != S_IDLE);
    O_mem_addr    = addr_q;
    O_mem_data    = wdata_q;
    O_mem_rden    = (state_q == S_ISSUE) && rd_q;
    O_mem_wren    = (state_q == S_ISSUE) && !rd_q;
    O_vid_ack     = (state_q == S_ACK) && !win_cpu_q;
    O_cpu_ack     = (state_q == S_ACK) && win_cpu_q;
    O_vid_data    = O_vid_ack ? I_mem_data : vid_data_q;
    O_cpu_rd_data = O_cpu_ack ? I_mem_data : cpu_data_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural synchronous memory.
module tb_mem_arbiter;

  logic        I_clock = 1'b0;
  logic        I_reset;
  logic        I_vid_req;
  logic [15:0] I_vid_addr;
  logic        O_vid_ack;
  logic [7:0]  O_vid_data;
  logic        I_cpu_req;
  logic        I_cpu_rdwr;
  logic [15:0] I_cpu_addr;
  logic [7:0]  I_cpu_wr_data;
  logic        O_cpu_ack;
  logic [7:0]  O_cpu_rd_data;
  logic [15:0] O_mem_addr;
  logic        O_mem_rden;
  logic        O_mem_wren;
  logic [7:0]  O_mem_data;
  logic [7:0]  I_mem_data = 8'h00;
  logic        O_busy;

  logic [7:0] mem [0:65535];
  int n_chk  = 0;
  int n_fail = 0;

  mem_arbiter #(.P_data_bits(8), .P_addr_bits(16), .P_cpu_max_wait(6)) dut (
    .I_clock(I_clock), .I_reset(I_reset),
    .I_vid_req(I_vid_req), .I_vid_addr(I_vid_addr),
    .O_vid_ack(O_vid_ack), .O_vid_data(O_vid_data),
    .I_cpu_req(I_cpu_req), .I_cpu_rdwr(I_cpu_rdwr), .I_cpu_addr(I_cpu_addr),
    .I_cpu_wr_data(I_cpu_wr_data), .O_cpu_ack(O_cpu_ack), .O_cpu_rd_data(O_cpu_rd_data),
    .O_mem_addr(O_mem_addr), .O_mem_rden(O_mem_rden), .O_mem_wren(O_mem_wren),
    .O_mem_data(O_mem_data), .I_mem_data(I_mem_data), .O_busy(O_busy)
  );

  always #5 I_clock = ~I_clock;

  always @(posedge I_clock) begin
    if (O_mem_rden) I_mem_data <= mem[O_mem_addr];
    if (O_mem_wren) mem[O_mem_addr] <= O_mem_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge I_clock);
    #1;
  endtask

  initial begin
    mem[16'h4800] = 8'h5A;
    mem[16'h1234] = 8'h11;
    mem[16'hFFFF] = 8'h22;
    mem[16'h0010] = 8'h44;
    mem[16'h0020] = 8'h55;
    mem[16'h00AB] = 8'h77;
    mem[16'h0200] = 8'h00;

    I_reset = 1'b1; I_vid_req = 1'b0; I_vid_addr = '0;
    I_cpu_req = 1'b0; I_cpu_rdwr = 1'b1; I_cpu_addr = '0; I_cpu_wr_data = '0;
    tick(); tick();
    chk("rst_busy", 32'(O_busy), 0);
    chk("rst_acks", {30'd0, O_vid_ack, O_cpu_ack}, 0);
    chk("rst_en", {30'd0, O_mem_rden, O_mem_wren}, 0);
    chk("rst_addr", 32'(O_mem_addr), 0);
    chk("rst_data", {16'd0, O_vid_data, O_cpu_rd_data}, 0);
    I_reset = 1'b0;
    tick();

    // CPU read alone
    I_cpu_req = 1'b1; I_cpu_rdwr = 1'b1; I_cpu_addr = 16'h4800;
    tick();
    chk("rd_issue_en", {30'd0, O_mem_rden, O_mem_wren}, 32'b10);
    chk("rd_issue_addr", 32'(O_mem_addr), 32'h4800);
    chk("rd_issue_busy", 32'(O_busy), 1);
    tick();
    chk("rd_ack", {30'd0, O_cpu_ack, O_vid_ack}, 32'b10);
    chk("rd_data", 32'(O_cpu_rd_data), 32'h5A);
    chk("rd_ack_en", {30'd0, O_mem_rden, O_mem_wren}, 0);
    I_cpu_req = 1'b0;
    tick();
    chk("rd_idle_ack", 32'(O_cpu_ack), 0);
    chk("rd_hold", 32'(O_cpu_rd_data), 32'h5A);
    chk("rd_idle_busy", 32'(O_busy), 0);

    // CPU write
    I_cpu_req = 1'b1; I_cpu_rdwr = 1'b0; I_cpu_addr = 16'h0200; I_cpu_wr_data = 8'h33;
    tick();
    chk("wr_issue_en", {30'd0, O_mem_rden, O_mem_wren}, 32'b01);
    chk("wr_issue_addr", 32'(O_mem_addr), 32'h0200);
    chk("wr_issue_data", 32'(O_mem_data), 32'h33);
    tick();
    chk("wr_ack", 32'(O_cpu_ack), 1);
    chk("wr_ack_en", {30'd0, O_mem_rden, O_mem_wren}, 0);
    I_cpu_req = 1'b0;
    tick();
    chk("wr_mem", 32'(mem[16'h0200]), 32'h33);
    chk("wr_idle_en", {30'd0, O_mem_rden, O_mem_wren}, 0);

    // Simultaneous requests: video first, CPU next
    I_vid_req = 1'b1; I_vid_addr = 16'h1234;
    I_cpu_req = 1'b1; I_cpu_rdwr = 1'b1; I_cpu_addr = 16'hFFFF;
    tick();
    chk("both_addr1", 32'(O_mem_addr), 32'h1234);
    tick();
    chk("both_ack1", {30'd0, O_vid_ack, O_cpu_ack}, 32'b10);
    chk("both_vdata", 32'(O_vid_data), 32'h11);
    I_vid_req = 1'b0;
    tick();
    chk("both_idle", 32'(O_busy), 0);
    tick();
    chk("both_addr2", 32'(O_mem_addr), 32'hFFFF);
    chk("both_rden2", 32'(O_mem_rden), 1);
    tick();
    chk("both_ack2", {30'd0, O_vid_ack, O_cpu_ack}, 32'b01);
    chk("both_cdata", 32'(O_cpu_rd_data), 32'h22);
    I_cpu_req = 1'b0;
    tick();
    chk("both_vhold", 32'(O_vid_data), 32'h11);

    // Starvation: CPU wins the 7th arbitration, then the counter restarts
    I_vid_req = 1'b1; I_vid_addr = 16'h0010;
    I_cpu_req = 1'b1; I_cpu_rdwr = 1'b1; I_cpu_addr = 16'h0020;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("starve_addr%0d", i), 32'(O_mem_addr), (i == 7) ? 32'h0020 : 32'h0010);
      tick();
      chk($sformatf("starve_ack%0d", i), {30'd0, O_vid_ack, O_cpu_ack},
          (i == 7) ? 32'b01 : 32'b10);
      if (i == 7) chk("starve_cdata", 32'(O_cpu_rd_data), 32'h55);
      tick();
    end
    I_vid_req = 1'b0; I_cpu_req = 1'b0;
    tick();

    // Reset during ISSUE abandons the access
    I_vid_req = 1'b1; I_vid_addr = 16'h1234;
    tick();
    chk("rsti_rden", 32'(O_mem_rden), 1);
    I_reset = 1'b1; I_vid_req = 1'b0;
    tick();
    chk("rsti_busy", 32'(O_busy), 0);
    chk("rsti_en", {30'd0, O_mem_rden, O_mem_wren}, 0);
    chk("rsti_acks", {30'd0, O_vid_ack, O_cpu_ack}, 0);
    chk("rsti_data", {16'd0, O_vid_data, O_cpu_rd_data}, 0);
    I_reset = 1'b0;
    tick();
    chk("rsti_noack", {30'd0, O_vid_ack, O_cpu_ack}, 0);

    // Video drops its request during ISSUE
    I_vid_req = 1'b1; I_vid_addr = 16'h00AB;
    tick();
    I_vid_req = 1'b0;
    chk("drop_rden", 32'(O_mem_rden), 1);
    tick();
    chk("drop_ack", 32'(O_vid_ack), 1);
    chk("drop_data", 32'(O_vid_data), 32'h77);
    tick();
    chk("drop_ack_off", 32'(O_vid_ack), 0);
    tick();
    chk("drop_noextra", {29'd0, O_busy, O_mem_rden, O_vid_ack}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
